vga_sync: RTL and testbench

VGA timing generator for the 640x480 display path. Runs entirely on the system clock and advances one pixel per rising edge of the divided pixel-rate signal produced by the clock divider, which it treats as a level input, not as a clock. Produces registered hsync/vsync, a visible-area flag, pixel coordinates and a start-of-frame pulse for the game's pixel renderer.

---
 rtl/vga_sync_if.sv | 27 ++
 rtl/vga_sync.sv | 116 +++++++++++
 tb/tb_vga_sync.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/vga_sync_if.sv
// vga_sync_if: bundles the pixel-rate input and the timing outputs of the
// VGA timing generator.
//   vgaClock    - divided pixel-rate level (sampled, never used as a clock)
//   hsync/vsync - registered sync pulses
//   video_on    - current pixel lies in the visible area
//   x/y         - current pixel column / line
//   frame_start - one-clk pulse when coordinates return to (0,0)
// master: the timing generator; slave: the pixel renderer side.
interface vga_sync_if;
   logic       vgaClock;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic [9:0] x;
   logic [9:0] y;
   logic       frame_start;

   modport master (
      input  vgaClock,
      output hsync, vsync, video_on, x, y, frame_start
   );

   modport slave (
      output vgaClock,
      input  hsync, vsync, video_on, x, y, frame_start
   );
endinterface

// File: rtl/vga_sync.sv
// vga_sync: 640x480 VGA timing generator. Runs on clk and advances one pixel
// per rising edge of the vgaClock level. All outputs are registered and lag
// the internal counters by one clk.
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   vga   - vga_sync_if master: vgaClock in; hsync, vsync, video_on, x, y,
//           frame_start out
module vga_sync #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter bit          SYNC_POL  = 1'b0
) (
   input logic         clk,
   input logic         reset,
   vga_sync_if.master  vga
);
   localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
   // Sync end bounds kept 11 bits wide so a sync region reaching the last
   // count of a 1024 total still compares correctly.
   localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FP + V_SYNC);

   logic       vclk_q;
   logic       tick;
   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   // Marks the cycle in which the counters sit at (0,0) because of a frame
   // wrap, so a reset-entered (0,0) never raises frame_start.
   logic       wrap_q, wrap_d;

   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       vid_q, vid_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       fs_q, fs_d;

   assign tick = vga.vgaClock & ~vclk_q;

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      wrap_d  = 1'b0;
      if (tick) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
               v_cnt_d = '0;
               wrap_d  = 1'b1;
            end else begin
               v_cnt_d = v_cnt_q + 10'd1;
            end
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
      end
   end

   always_comb begin
      x_d   = h_cnt_q;
      y_d   = v_cnt_q;
      vid_d = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      hs_d  = ~SYNC_POL;
      vs_d  = ~SYNC_POL;
      if ((h_cnt_q >= HS_BEG) && ({1'b0, h_cnt_q} < HS_END)) hs_d = SYNC_POL;
      if ((v_cnt_q >= VS_BEG) && ({1'b0, v_cnt_q} < VS_END)) vs_d = SYNC_POL;
      fs_d  = wrap_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vclk_q  <= 1'b0;
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         wrap_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         vid_q   <= 1'b0;
         hs_q    <= ~SYNC_POL;
         vs_q    <= ~SYNC_POL;
         fs_q    <= 1'b0;
      end else begin
         vclk_q  <= vga.vgaClock;
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         wrap_q  <= wrap_d;
         x_q     <= x_d;
         y_q     <= y_d;
         vid_q   <= vid_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         fs_q    <= fs_d;
      end
   end

   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.video_on    = vid_q;
   assign vga.hsync       = hs_q;
   assign vga.vsync       = vs_q;
   assign vga.frame_start = fs_q;
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: drives vga_sync with a reduced timing set so whole frames fit
// in a short run. The reference tracks only the number of pixel ticks since
// reset; coordinates, sync levels and frame pulses are derived from that
// count with division and modulo.
module tb_vga_sync;
   localparam int HV = 16, HF = 4, HS = 6, HB = 4;
   localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
   localparam bit POL = 1'b0;
   localparam int HT = HV + HF + HS + HB;  // 30
   localparam int VT = VV + VF + VS + VB;  // 15
   localparam int FR = HT * VT;            // ticks per frame

   logic clk;
   logic reset;
   vga_sync_if vif ();

   vga_sync #(
      .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(POL)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .vga  (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: tick count now (n), during the previous cycle (n1)
   // and the cycle before (n2); prv is the last sampled vgaClock level.
   int n = 0, n1 = 0, n2 = 0;
   bit prv = 1'b0;
   int fs_seen = 0, fs_exp = 0;

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".x"},  vif.x, 10'd0);
      chk({tag, ".y"},  vif.y, 10'd0);
      chk({tag, ".vid"}, {9'd0, vif.video_on}, 10'd0);
      chk({tag, ".hs"}, {9'd0, vif.hsync}, {9'd0, ~POL});
      chk({tag, ".vs"}, {9'd0, vif.vsync}, {9'd0, ~POL});
      chk({tag, ".fs"}, {9'd0, vif.frame_start}, 10'd0);
   endtask

   function automatic int cur_h();
      return n % HT;
   endfunction

   // One clk: drive vgaClock, advance the reference at the edge, compare at
   // the following falling edge.
   task automatic cyc(input logic vc, input string tag);
      int h, v;
      bit vid, hs, vs, fs;
      vif.vgaClock = vc;
      @(posedge clk);
      if (reset) begin
         n = 0; n1 = 0; n2 = 0; prv = 1'b0;
      end else begin
         n2 = n1;
         n1 = n;
         if (vc && !prv) n++;
         prv = vc;
      end
      @(negedge clk);
      if (reset) begin
         chk_reset_vals(tag);
      end else begin
         h   = n1 % HT;
         v   = (n1 / HT) % VT;
         vid = (h < HV) && (v < VV);
         hs  = (h >= HV + HF && h < HV + HF + HS) ? POL : ~POL;
         vs  = (v >= VV + VF && v < VV + VF + VS) ? POL : ~POL;
         fs  = (n1 != n2) && (n1 > 0) && (n1 % FR == 0);
         if (fs) fs_exp++;
         if (vif.frame_start === 1'b1) fs_seen++;
         chk({tag, ".x"},  vif.x, 10'(h));
         chk({tag, ".y"},  vif.y, 10'(v));
         chk({tag, ".vid"}, {9'd0, vif.video_on}, {9'd0, vid});
         chk({tag, ".hs"}, {9'd0, vif.hsync}, {9'd0, hs});
         chk({tag, ".vs"}, {9'd0, vif.vsync}, {9'd0, vs});
         chk({tag, ".fs"}, {9'd0, vif.frame_start}, {9'd0, fs});
      end
   endtask

   initial begin
      logic [1:0] c2;
      bit found;
      reset = 1'b1;
      vif.vgaClock = 1'b0;

      // Reset held, vgaClock low.
      for (int i = 0; i < 4; i++) cyc(1'b0, "rst_hold");
      reset = 1'b0;
      // Released with vgaClock stuck low: frozen at (0,0) with video_on.
      for (int i = 0; i < 6; i++) cyc(1'b0, "stuck_low");

      // vgaClock = bit 1 of a free-running 2-bit counter: tick every 4 clk.
      c2 = 2'd0;
      for (int i = 0; i < 2 * FR * 4 + 40; i++) begin
         cyc(c2[1], "div4");
         c2 = c2 + 2'd1;
      end

      // Maximum rate: vgaClock toggles every clk.
      for (int i = 0; i < FR * 2 + 30; i++) cyc(1'(i % 2), "div2");

      // Random levels.
      for (int i = 0; i < 4000; i++) cyc(1'($urandom % 2), "rand");

      // Park at h=10 then hold vgaClock high: coordinates must stay put.
      found = 1'b0;
      for (int i = 0; i < 4 * HT + 8 && !found; i++) begin
         if (cur_h() == 10 && !prv) found = 1'b1;
         else cyc(1'(i % 2), "seek");
      end
      chk("seek_found", {9'd0, found}, 10'd1);
      for (int i = 0; i < 100; i++) cyc(1'b1, "hold_hi");
      for (int i = 0; i < 60; i++) cyc(1'(i % 2), "resume");

      // Advance into mid-frame (h>0, v>0), then assert reset between edges.
      found = 1'b0;
      c2 = 2'd0;
      for (int i = 0; i < 4 * FR + 8 && !found; i++) begin
         if ((n % HT) > 3 && ((n / HT) % VT) > 2 && ((n / HT) % VT) < VV) found = 1'b1;
         else begin
            cyc(c2[1], "seek2");
            c2 = c2 + 2'd1;
         end
      end
      chk("seek2_found", {9'd0, found}, 10'd1);
      #2 reset = 1'b1;
      #1 chk_reset_vals("async_rst");
      for (int i = 0; i < 3; i++) cyc(1'b0, "rst_mid");
      reset = 1'b0;
      c2 = 2'd0;
      for (int i = 0; i < FR * 4 + 40; i++) begin
         cyc(c2[1], "after_rst");
         c2 = c2 + 2'd1;
      end

      chk("fs_total", 10'(fs_seen), 10'(fs_exp));
      chk("fs_nonzero", {9'd0, (fs_exp >= 4)}, 10'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
